// File: rtl/id_ex_regfile.sv
// LEGv8 ID-stage register file with a write-through WB bypass, fused with the ID/EX pipeline register.
// Index ZERO_REG (XZR) has no storage and always reads as zero.
module id_ex_regfile #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       Rd_MEM_WB,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       Rn,
  input  logic [4:0]       Rm,
  input  logic             valid_ID,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] ReadData1_EX,
  output logic [WIDTH-1:0] ReadData2_EX,
  output logic [4:0]       Rn_EX,
  output logic [4:0]       Rm_EX,
  output logic             fwd1_EX,
  output logic             fwd2_EX,
  output logic             valid_EX
);

  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREGS-1];
  logic [WIDTH-1:0] regs_d [NREGS-1];

  logic             wr_en;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             hit_a, hit_b;

  logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [4:0]       rn_q, rn_d, rm_q, rm_d;
  logic             fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic             valid_q, valid_d;

  always_comb begin
    wr_en  = RegWrite && (Rd_MEM_WB != ZERO_IDX);
    regs_d = regs_q;
    if (wr_en) regs_d[Rd_MEM_WB] = WriteData;
  end

  // The two read ports resolve independently; both may hit the same WB write.
  always_comb begin
    rd_a  = '0;
    hit_a = 1'b0;
    if (Rn != ZERO_IDX) begin
      if (RegWrite && (Rd_MEM_WB == Rn)) begin
        rd_a  = WriteData;
        hit_a = 1'b1;
      end else begin
        rd_a  = regs_q[Rn];
      end
    end
  end

  always_comb begin
    rd_b  = '0;
    hit_b = 1'b0;
    if (Rm != ZERO_IDX) begin
      if (RegWrite && (Rd_MEM_WB == Rm)) begin
        rd_b  = WriteData;
        hit_b = 1'b1;
      end else begin
        rd_b  = regs_q[Rm];
      end
    end
  end

  // While stalled, a WB write to a held source index refreshes that operand so it cannot go stale.
  always_comb begin
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    fwd1_d  = fwd1_q;
    fwd2_d  = fwd2_q;
    valid_d = valid_q;
    if (flush) begin
      rd1_d   = '0;
      rd2_d   = '0;
      rn_d    = ZERO_IDX;
      rm_d    = ZERO_IDX;
      fwd1_d  = 1'b0;
      fwd2_d  = 1'b0;
      valid_d = 1'b0;
    end else if (stall) begin
      if (wr_en && (Rd_MEM_WB == rn_q)) begin
        rd1_d  = WriteData;
        fwd1_d = 1'b1;
      end
      if (wr_en && (Rd_MEM_WB == rm_q)) begin
        rd2_d  = WriteData;
        fwd2_d = 1'b1;
      end
    end else begin
      rd1_d   = rd_a;
      rd2_d   = rd_b;
      rn_d    = Rn;
      rm_d    = Rm;
      fwd1_d  = hit_a;
      fwd2_d  = hit_b;
      valid_d = valid_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) regs_q[i] <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rn_q    <= ZERO_IDX;
      rm_q    <= ZERO_IDX;
      fwd1_q  <= 1'b0;
      fwd2_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
      valid_q <= valid_d;
    end
  end

  assign ReadData1_EX = rd1_q;
  assign ReadData2_EX = rd2_q;
  assign Rn_EX        = rn_q;
  assign Rm_EX        = rm_q;
  assign fwd1_EX      = fwd1_q;
  assign fwd2_EX      = fwd2_q;
  assign valid_EX     = valid_q;

endmodule

// File: tb/tb_id_ex_regfile.sv
// Scoreboard bench for id_ex_regfile: a driver runs an architectural model and queues the expected
// ID/EX contents for every clock; a separate monitor pops and compares them just after each edge.
module tb_id_ex_regfile;

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        f1;
    logic        f2;
    logic        v;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  Rd_MEM_WB = '0;
  logic [63:0] WriteData = '0;
  logic [4:0]  Rn = '0;
  logic [4:0]  Rm = '0;
  logic        valid_ID = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] ReadData1_EX, ReadData2_EX;
  logic [4:0]  Rn_EX, Rm_EX;
  logic        fwd1_EX, fwd2_EX, valid_EX;

  int vectors = 0;
  int miscompares = 0;

  ex_t         exp_q[$];
  logic [63:0] arch[32];
  ex_t         mdl_ex;

  id_ex_regfile dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .Rd_MEM_WB(Rd_MEM_WB),
    .WriteData(WriteData), .Rn(Rn), .Rm(Rm), .valid_ID(valid_ID),
    .stall(stall), .flush(flush),
    .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
    .Rn_EX(Rn_EX), .Rm_EX(Rm_EX), .fwd1_EX(fwd1_EX), .fwd2_EX(fwd2_EX),
    .valid_EX(valid_EX)
  );

  always #5 clk = ~clk;

  // Architectural view: what an instruction reading register r in this cycle must observe.
  function automatic logic [63:0] archRead(input logic [4:0] r);
    if (r == 5'd31) return 64'd0;
    if (RegWrite && Rd_MEM_WB == r) return WriteData;
    return arch[r];
  endfunction

  function automatic ex_t bubble();
    ex_t b;
    b = '0;
    b.rn = 5'd31;
    b.rm = 5'd31;
    return b;
  endfunction

  task automatic modelEdge();
    logic writes;
    writes = RegWrite && (Rd_MEM_WB != 5'd31);
    if (reset) begin
      foreach (arch[i]) arch[i] = 64'd0;
      mdl_ex = bubble();
    end else begin
      if (flush) begin
        mdl_ex = bubble();
      end else if (stall) begin
        if (writes && Rd_MEM_WB == mdl_ex.rn) begin mdl_ex.d1 = WriteData; mdl_ex.f1 = 1'b1; end
        if (writes && Rd_MEM_WB == mdl_ex.rm) begin mdl_ex.d2 = WriteData; mdl_ex.f2 = 1'b1; end
      end else begin
        mdl_ex.d1 = archRead(Rn);
        mdl_ex.d2 = archRead(Rm);
        mdl_ex.rn = Rn;
        mdl_ex.rm = Rm;
        mdl_ex.f1 = writes && Rd_MEM_WB == Rn;
        mdl_ex.f2 = writes && Rd_MEM_WB == Rm;
        mdl_ex.v  = valid_ID;
      end
      if (writes) arch[Rd_MEM_WB] = WriteData;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] rd,
                               input logic [63:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                               input logic vld, input logic stl, input logic fl);
    reset = rst; RegWrite = we; Rd_MEM_WB = rd; WriteData = wd;
    Rn = ra; Rm = rb; valid_ID = vld; stall = stl; flush = fl;
    @(posedge clk);
    modelEdge();
    exp_q.push_back(mdl_ex);
    @(negedge clk);
  endtask

  task automatic checkOutput(input ex_t exp_v);
    ex_t act;
    act = '{ReadData1_EX, ReadData2_EX, Rn_EX, Rm_EX, fwd1_EX, fwd2_EX, valid_EX};
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL ex_regs @%0t: got d1=%h d2=%h rn=%0d rm=%0d f1=%b f2=%b v=%b, want d1=%h d2=%h rn=%0d rm=%0d f1=%b f2=%b v=%b",
               $time, act.d1, act.d2, act.rn, act.rm, act.f1, act.f2, act.v,
               exp_v.d1, exp_v.d2, exp_v.rn, exp_v.rm, exp_v.f1, exp_v.f2, exp_v.v);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  function automatic logic [4:0] pickIdx();
    int r;
    r = $urandom_range(0, 9);
    if (r == 9) return 5'd31;
    if (r == 8) return 5'($urandom_range(0, 31));
    return 5'(r);
  endfunction

  initial begin : driver
    int wait_cycles;
    mdl_ex = bubble();
    foreach (arch[i]) arch[i] = 64'd0;
    @(negedge clk);
    // reset, then read X5
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 5, 5, 1, 0, 0);
    // write X3, then read it on both ports
    applyStimulus(0, 1, 3, 64'hAAAA, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 3, 3, 1, 0, 0);
    // same-cycle bypass on port A only
    applyStimulus(0, 1, 2, 64'h55, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 7, 64'h1234, 7, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 7, 7, 1, 0, 0);
    // XZR write ignored
    applyStimulus(0, 1, 31, 64'hFFFF, 31, 31, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 31, 3, 1, 0, 0);
    // stall refresh of a held operand
    applyStimulus(0, 1, 4, 64'h10, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 4, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 9, 9, 1, 1, 0);
    applyStimulus(0, 1, 4, 64'h20, 9, 9, 1, 1, 0);
    // flush beats stall; write still lands
    applyStimulus(0, 1, 9, 64'h9999, 4, 4, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 9, 4, 1, 0, 0);
    // both ports hit the same write
    applyStimulus(0, 1, 6, 64'hDEAD_BEEF_0000_0006, 6, 6, 1, 0, 0);

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 55),
                    pickIdx(),
                    {$urandom, $urandom},
                    pickIdx(), pickIdx(),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 25),
                    ($urandom_range(0, 99) < 8));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
